ram_1r1w_dense: RTL

//  Dense dual-port RAM: one write port, one read port, independent valid/retry handshakes.

---
 rtl/ram_1r1w_dense_pkg.sv | 20 ++
 rtl/ram_1r1w_dense_if.sv | 27 ++
 rtl/ram_1r1w_dense_ack_fifo.sv | 56 +++++
 rtl/ram_1r1w_dense.sv | 101 ++++++++++
 4 files changed

// File: rtl/ram_1r1w_dense_pkg.sv
// Shared definitions for ram_1r1w_dense: FSM state encodings, log2 and parity helpers.
package ram_1r1w_dense_pkg;

    localparam logic [0:0] RAM_ST_INIT = 1'b0;
    localparam logic [0:0] RAM_ST_RUN  = 1'b1;

    // Smallest r with 2**r >= n; used for address and counter widths.
    function automatic int ram_log2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Even parity; callers zero-extend narrower words, which leaves the result unchanged.
    function automatic logic ram_parity(input logic [63:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/ram_1r1w_dense_if.sv
// Write, read and read-ack channels of ram_1r1w_dense, each with its own valid/retry pair.
interface ram_1r1w_dense_if #(
    parameter int Width = 16,
    parameter int AW    = 8
);
    logic             wr_valid;
    logic             wr_retry;
    logic [AW-1:0]    wr_addr;
    logic [Width-1:0] wr_data;
    logic             rd_valid;
    logic             rd_retry;
    logic [AW-1:0]    rd_addr;
    logic             ack_valid;
    logic             ack_retry;
    logic [Width-1:0] ack_data;
    logic             ack_perr;

    modport master (
        output wr_valid, wr_addr, wr_data, rd_valid, rd_addr, ack_retry,
        input  wr_retry, rd_retry, ack_valid, ack_data, ack_perr
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr, ack_retry,
        output wr_retry, rd_retry, ack_valid, ack_data, ack_perr
    );
endinterface

// File: rtl/ram_1r1w_dense_ack_fifo.sv
// Small valid/retry FIFO holding read results until the consumer takes them.
module ram_ack_fifo
    import ram_1r1w_dense_pkg::*;
#(
    parameter int Width = 17,
    parameter int Depth = 2,
    parameter int CW    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_valid,
    output logic             o_retry,
    input  logic [Width-1:0] i_data,
    output logic             o_valid,
    input  logic             i_retry,
    output logic [Width-1:0] o_data,
    output logic [CW-1:0]    o_count
);
    localparam int IW = ram_log2(Depth);

    logic [Width-1:0] r_buf [Depth];
    logic [IW-1:0]    r_wr_idx;
    logic [IW-1:0]    r_rd_idx;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_retry = (r_count == CW'(Depth));
    assign o_valid = (r_count != '0);
    assign o_data  = r_buf[r_rd_idx];
    assign o_count = r_count;
    assign w_push  = i_valid && !o_retry;
    assign w_pop   = o_valid && !i_retry;

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
        return (idx == IW'(Depth - 1)) ? '0 : idx + 1'b1;
    endfunction

    // Entries are cleared on reset so the ack data bus idles at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < Depth; i++) r_buf[i] <= '0;
            r_wr_idx <= '0;
            r_rd_idx <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_buf[r_wr_idx] <= i_data;
                r_wr_idx        <= next_idx(r_wr_idx);
            end
            if (w_pop) r_rd_idx <= next_idx(r_rd_idx);
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (w_pop && !w_push) r_count <= r_count - 1'b1;
        end
    end
endmodule

// File: rtl/ram_1r1w_dense.sv
// Dense 1-read/1-write RAM with self-clearing INIT sweep and a skid FIFO on the read ack.
// Optional stored even parity when RAM_1R1W_PARITY_EN is defined.
module ram_1r1w_dense
    import ram_1r1w_dense_pkg::*;
#(
    parameter int Width    = 16,
    parameter int Size     = 256,
    parameter int Forward  = 1,
    parameter int AckDepth = 2
) (
    input logic            clk,
    input logic            reset,
    ram_1r1w_dense_if.slave bus
);
    localparam int AW = ram_log2(Size);
    localparam int CW = ram_log2(AckDepth + 1);
`ifdef RAM_1R1W_PARITY_EN
    localparam int MW = Width + 1;
`else
    localparam int MW = Width;
`endif

    logic [0:0]    r_state;
    logic [AW-1:0] r_ptr;
    logic          r_inflight;
    logic [MW-1:0] r_rd_word;
    logic [MW-1:0] r_mem [Size];

    logic          w_init;
    logic          w_wr_acc;
    logic          w_rd_acc;
    logic          w_rd_retry;
    logic          w_fwd;
    logic [MW-1:0] w_wr_word;
    logic [MW-1:0] w_ack_word;
    logic [CW-1:0] w_count;
    logic          w_fifo_full;
    logic          w_ack_valid;

    assign w_init     = (r_state == RAM_ST_INIT);
    // A read is admitted only if the FIFO still has room once the in-flight read lands.
    assign w_rd_retry = w_init || w_fifo_full
                     || (r_inflight && (w_count == CW'(AckDepth - 1)));
    assign w_wr_acc   = bus.wr_valid && !w_init;
    assign w_rd_acc   = bus.rd_valid && !w_rd_retry;
    assign w_fwd      = (Forward != 0) && w_wr_acc && (bus.wr_addr == bus.rd_addr);

`ifdef RAM_1R1W_PARITY_EN
    assign w_wr_word  = {ram_parity(64'(bus.wr_data)), bus.wr_data};
    assign bus.ack_perr = ram_parity(64'(w_ack_word[Width-1:0])) != w_ack_word[Width];
`else
    assign w_wr_word  = bus.wr_data;
    assign bus.ack_perr = 1'b0;
`endif

    assign bus.wr_retry  = w_init;
    assign bus.rd_retry  = w_rd_retry;
    assign bus.ack_valid = w_ack_valid;
    assign bus.ack_data  = w_ack_word[Width-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= RAM_ST_INIT;
            r_ptr   <= '0;
        end else if (w_init) begin
            r_ptr <= r_ptr + 1'b1;
            if (r_ptr == AW'(Size - 1)) r_state <= RAM_ST_RUN;
        end
    end

    // NOTE: the array itself has no reset; the INIT sweep clears it one word per cycle.
    always_ff @(posedge clk) begin
        if (w_init)        r_mem[r_ptr]       <= '0;
        else if (w_wr_acc) r_mem[bus.wr_addr] <= w_wr_word;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_inflight <= 1'b0;
        else       r_inflight <= w_rd_acc;
    end

    always_ff @(posedge clk) begin
        if (w_rd_acc) r_rd_word <= w_fwd ? w_wr_word : r_mem[bus.rd_addr];
    end

    ram_ack_fifo #(
        .Width (MW),
        .Depth (AckDepth),
        .CW    (CW)
    ) u_ack_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_valid (r_inflight),
        .o_retry (w_fifo_full),
        .i_data  (r_rd_word),
        .o_valid (w_ack_valid),
        .i_retry (bus.ack_retry),
        .o_data  (w_ack_word),
        .o_count (w_count)
    );
endmodule
